// File: rtl/tx_fifo_if.sv
// Handshake bundle between the TX FIFO and its producers (APB CSR, DMA) and consumer (QSPI FSM).
// The slave modport is the FIFO side; the master modport is the controller side that drives it.
interface tx_fifo_if #(
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
);
    logic                  fifo_tx_we_o;
    logic [DATA_WIDTH-1:0] fifo_tx_data_o;
    logic                  dma_wr_en;
    logic [DATA_WIDTH-1:0] dma_wr_data;
    logic                  dma_wr_ready;
    logic                  dma_req;
    logic [LVL_W-1:0]      tx_thresh;
    logic                  tx_flush;
    logic                  err_clr;
    logic                  tx_ren;
    logic [DATA_WIDTH-1:0] tx_data_fifo;
    logic                  tx_valid;
    logic [LVL_W-1:0]      tx_level;
    logic                  tx_full;
    logic                  tx_empty;
    logic                  overflow;
    logic                  underrun;

    modport slave (
        input  fifo_tx_we_o, fifo_tx_data_o, dma_wr_en, dma_wr_data,
               tx_thresh, tx_flush, err_clr, tx_ren,
        output dma_wr_ready, dma_req, tx_data_fifo, tx_valid, tx_level,
               tx_full, tx_empty, overflow, underrun
    );

    modport master (
        output fifo_tx_we_o, fifo_tx_data_o, dma_wr_en, dma_wr_data,
               tx_thresh, tx_flush, err_clr, tx_ren,
        input  dma_wr_ready, dma_req, tx_data_fifo, tx_valid, tx_level,
               tx_full, tx_empty, overflow, underrun
    );
endinterface

// File: rtl/tx_fifo.sv
// QSPI transmit FIFO: CSR-over-DMA push arbitration, first-word-fall-through head,
// watermark DMA request and sticky overflow/underrun flags.
module tx_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic      clk,
    input  logic      rst,
    tx_fifo_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("tx_fifo: FIFO_DEPTH must be a power of 2 and at least 4");
    end

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [LVL_W-1:0]      level;
    logic                  overflow_q;
    logic                  underrun_q;

    logic                  full;
    logic                  empty;
    logic                  push_csr;
    logic                  push_dma;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] wdata;

    // Full/empty come from the registered level, so a push+pop on a full FIFO only pops
    // and a push+pop on an empty FIFO only pushes.
    assign full     = (level == LVL_W'(FIFO_DEPTH));
    assign empty    = (level == '0);
    assign push_csr = bus.fifo_tx_we_o & ~full;
    assign push_dma = bus.dma_wr_en & ~bus.fifo_tx_we_o & ~full;
    assign push     = push_csr | push_dma;
    assign pop      = bus.tx_ren & ~empty;
    assign wdata    = bus.fifo_tx_we_o ? bus.fifo_tx_data_o : bus.dma_wr_data;

    // NOTE: storage has no reset; only pointers and level define which entries are valid.
    always_ff @(posedge clk) begin
        if (push && !rst && !bus.tx_flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples
    // the same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            // A DMA push while full is back-pressured by dma_wr_ready, so only CSR writes overflow.
            if (bus.fifo_tx_we_o && full) begin
                overflow_q <= 1'b1;
            end else if (bus.err_clr) begin
                overflow_q <= 1'b0;
            end

            if (bus.tx_ren && empty) begin
                underrun_q <= 1'b1;
            end else if (bus.err_clr) begin
                underrun_q <= 1'b0;
            end

            if (bus.tx_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   level <= level + LVL_W'(1);
                    2'b01:   level <= level - LVL_W'(1);
                    default: level <= level;
                endcase
            end
        end
    end

    assign bus.tx_data_fifo = mem[rd_ptr];
    assign bus.tx_valid     = ~empty;
    assign bus.tx_level     = level;
    assign bus.tx_full      = full;
    assign bus.tx_empty     = empty;
    assign bus.overflow     = overflow_q;
    assign bus.underrun     = underrun_q;
    assign bus.dma_wr_ready = ~full & ~bus.fifo_tx_we_o;
    assign bus.dma_req      = (level <= bus.tx_thresh);
endmodule

// File: tb/tb_tx_fifo.sv
// Directed bench for tx_fifo: a table of single-cycle vectors plus hand-written
// sequences for fill/overflow, full and empty push+pop, pointer wrap, flush and reset.
module tb_tx_fifo;
    localparam int DEPTH = 16;
    localparam int DW    = 32;

    logic clk = 1'b0;
    logic rst;

    tx_fifo_if #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW)) bus ();

    tx_fifo #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic [31:0] csr_d;
        logic        dma;
        logic [31:0] dma_d;
        logic        ren;
        logic        clr;
        logic        exp_rdy;
        int          exp_lvl;
        logic [31:0] exp_head;
        logic        exp_ovf;
        logic        exp_udr;
        logic        exp_req;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.fifo_tx_we_o   = 1'b0;
        bus.fifo_tx_data_o = '0;
        bus.dma_wr_en      = 1'b0;
        bus.dma_wr_data    = '0;
        bus.tx_flush       = 1'b0;
        bus.err_clr        = 1'b0;
        bus.tx_ren         = 1'b0;
    endtask

    // One clock with the currently driven inputs, then inputs return to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic add(input logic we, input logic [31:0] csr_d, input logic dma,
                       input logic [31:0] dma_d, input logic ren, input logic clr,
                       input logic exp_rdy, input int exp_lvl, input logic [31:0] exp_head,
                       input logic exp_ovf, input logic exp_udr, input logic exp_req);
        vec_t v;
        v = '{we, csr_d, dma, dma_d, ren, clr, exp_rdy, exp_lvl, exp_head, exp_ovf, exp_udr, exp_req};
        vecs.push_back(v);
    endtask

    task automatic chk_status(input string tag, input int lvl, input logic ovf, input logic udr);
        check({tag, " level"},    32'(bus.tx_level), 32'(lvl));
        check({tag, " empty"},    32'(bus.tx_empty), 32'(lvl == 0));
        check({tag, " full"},     32'(bus.tx_full),  32'(lvl == DEPTH));
        check({tag, " valid"},    32'(bus.tx_valid), 32'(lvl != 0));
        check({tag, " overflow"}, 32'(bus.overflow), 32'(ovf));
        check({tag, " underrun"}, 32'(bus.underrun), 32'(udr));
    endtask

    initial begin
        idle();
        bus.tx_thresh = 5'd4;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk_status("reset", 0, 1'b0, 1'b0);
        check("reset dma_req", 32'(bus.dma_req), 32'd1);
        check("reset dma_wr_ready", 32'(bus.dma_wr_ready), 32'd1);

        // ---- table-driven single-cycle vectors (tx_thresh = 4) ----
        add(1'b1, 32'hA0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1, 32'hA0, 1'b0, 1'b0, 1'b1);
        add(1'b1, 32'hA1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2, 32'hA0, 1'b0, 1'b0, 1'b1);
        add(1'b1, 32'hA2, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3, 32'hA0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 32'h0,  1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 2, 32'hA1, 1'b0, 1'b0, 1'b1);
        add(1'b0, 32'h0,  1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1, 32'hA2, 1'b0, 1'b0, 1'b1);
        add(1'b0, 32'h0,  1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 0, 32'h0,  1'b0, 1'b0, 1'b1);
        add(1'b0, 32'h0,  1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 0, 32'h0,  1'b0, 1'b1, 1'b1);
        add(1'b0, 32'h0,  1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 0, 32'h0,  1'b0, 1'b1, 1'b1);
        add(1'b0, 32'h0,  1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 0, 32'h0,  1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            add(1'b0, 32'h0, 1'b1, 32'hB0 + 32'(i), 1'b0, 1'b0, 1'b1, i + 1, 32'hB0,
                1'b0, 1'b0, logic'((i + 1) <= 4));
        end
        add(1'b1, 32'hC0, 1'b1, 32'hD0, 1'b0, 1'b0, 1'b0, 6, 32'hB0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 32'h0,  1'b1, 32'hD0, 1'b0, 1'b0, 1'b1, 7, 32'hB0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 6, 32'hB1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 5, 32'hB2, 1'b0, 1'b0, 1'b0);
        add(1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 4, 32'hB3, 1'b0, 1'b0, 1'b1);
        add(1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 3, 32'hB4, 1'b0, 1'b0, 1'b1);
        add(1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 2, 32'hC0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1, 32'hD0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 0, 32'h0,  1'b0, 1'b0, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            bus.fifo_tx_we_o   = vecs[i].we;
            bus.fifo_tx_data_o = vecs[i].csr_d;
            bus.dma_wr_en      = vecs[i].dma;
            bus.dma_wr_data    = vecs[i].dma_d;
            bus.tx_ren         = vecs[i].ren;
            bus.err_clr        = vecs[i].clr;
            #1;
            check($sformatf("v%0d dma_wr_ready", i), 32'(bus.dma_wr_ready), 32'(vecs[i].exp_rdy));
            tick();
            check($sformatf("v%0d level", i), 32'(bus.tx_level), 32'(vecs[i].exp_lvl));
            check($sformatf("v%0d empty", i), 32'(bus.tx_empty), 32'(vecs[i].exp_lvl == 0));
            if (vecs[i].exp_lvl != 0)
                check($sformatf("v%0d head", i), bus.tx_data_fifo, vecs[i].exp_head);
            check($sformatf("v%0d overflow", i), 32'(bus.overflow), 32'(vecs[i].exp_ovf));
            check($sformatf("v%0d underrun", i), 32'(bus.underrun), 32'(vecs[i].exp_udr));
            check($sformatf("v%0d dma_req", i), 32'(bus.dma_req), 32'(vecs[i].exp_req));
        end

        // ---- fill via DMA, overflow on CSR, back-pressure on DMA ----
        for (int i = 0; i < DEPTH; i++) begin
            bus.dma_wr_en   = 1'b1;
            bus.dma_wr_data = 32'h100 + 32'(i);
            tick();
        end
        chk_status("fill", DEPTH, 1'b0, 1'b0);
        check("fill dma_req", 32'(bus.dma_req), 32'd0);
        check("fill dma_wr_ready", 32'(bus.dma_wr_ready), 32'd0);
        bus.dma_wr_en   = 1'b1;
        bus.dma_wr_data = 32'hBEEF;
        tick();
        chk_status("dma while full", DEPTH, 1'b0, 1'b0);
        bus.fifo_tx_we_o   = 1'b1;
        bus.fifo_tx_data_o = 32'hDEAD;
        tick();
        chk_status("csr while full", DEPTH, 1'b1, 1'b0);
        bus.err_clr = 1'b1;
        tick();
        check("ovf cleared", 32'(bus.overflow), 32'd0);

        // Full push+pop: push rejected (and flagged), oldest word popped.
        bus.fifo_tx_we_o   = 1'b1;
        bus.fifo_tx_data_o = 32'hCAFE;
        bus.tx_ren         = 1'b1;
        #1;
        check("full pushpop head", bus.tx_data_fifo, 32'h100);
        tick();
        chk_status("full pushpop", DEPTH - 1, 1'b1, 1'b0);
        check("full pushpop next", bus.tx_data_fifo, 32'h101);
        for (int i = 1; i < DEPTH; i++) begin
            check($sformatf("drain %0d", i), bus.tx_data_fifo, 32'h100 + 32'(i));
            bus.tx_ren = 1'b1;
            tick();
        end
        chk_status("drained", 0, 1'b1, 1'b0);
        bus.err_clr = 1'b1;
        tick();

        // Empty push+pop: push taken, pop rejected and flagged.
        bus.fifo_tx_we_o   = 1'b1;
        bus.fifo_tx_data_o = 32'h55;
        bus.tx_ren         = 1'b1;
        tick();
        chk_status("empty pushpop", 1, 1'b0, 1'b1);
        check("empty pushpop head", bus.tx_data_fifo, 32'h55);
        bus.err_clr = 1'b1;
        tick();
        check("udr cleared", 32'(bus.underrun), 32'd0);

        // ---- 40 push+pop cycles across pointer wrap ----
        exp_q.delete();
        exp_q.push_back(32'h55);
        for (int i = 0; i < 40; i++) begin
            bus.fifo_tx_we_o   = 1'b1;
            bus.fifo_tx_data_o = 32'h1000 + 32'(i);
            bus.tx_ren         = 1'b1;
            #1;
            check($sformatf("wrap %0d", i), bus.tx_data_fifo, exp_q[0]);
            exp_q.push_back(32'h1000 + 32'(i));
            void'(exp_q.pop_front());
            tick();
        end
        chk_status("wrap end", 1, 1'b0, 1'b0);
        check("wrap end head", bus.tx_data_fifo, exp_q[0]);

        // Threshold boundaries at level 1.
        bus.tx_thresh = 5'd0;
        #1;
        check("thresh0 dma_req", 32'(bus.dma_req), 32'd0);
        bus.tx_thresh = 5'd16;
        #1;
        check("thresh16 dma_req", 32'(bus.dma_req), 32'd1);
        bus.tx_thresh = 5'd4;

        // ---- flush keeps errors ----
        bus.tx_ren = 1'b1;
        tick();
        bus.tx_ren = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) begin
            bus.fifo_tx_we_o   = 1'b1;
            bus.fifo_tx_data_o = 32'h200 + 32'(i);
            tick();
        end
        chk_status("pre flush", 9, 1'b0, 1'b1);
        check("pre flush dma_req", 32'(bus.dma_req), 32'd0);
        bus.tx_flush       = 1'b1;
        bus.fifo_tx_we_o   = 1'b1;
        bus.fifo_tx_data_o = 32'h999;
        bus.tx_ren         = 1'b1;
        tick();
        chk_status("flush", 0, 1'b0, 1'b1);
        check("flush dma_req", 32'(bus.dma_req), 32'd1);
        bus.fifo_tx_we_o   = 1'b1;
        bus.fifo_tx_data_o = 32'h77;
        tick();
        chk_status("post flush", 1, 1'b0, 1'b1);
        check("post flush head", bus.tx_data_fifo, 32'h77);

        // ---- reset mid-burst ----
        for (int i = 0; i < 3; i++) begin
            bus.fifo_tx_we_o   = 1'b1;
            bus.fifo_tx_data_o = 32'h300 + 32'(i);
            tick();
        end
        rst                = 1'b1;
        bus.fifo_tx_we_o   = 1'b1;
        bus.fifo_tx_data_o = 32'h400;
        bus.dma_wr_en      = 1'b1;
        bus.tx_ren         = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        #1;
        chk_status("mid reset", 0, 1'b0, 1'b0);
        check("mid reset dma_req", 32'(bus.dma_req), 32'd1);
        check("mid reset dma_wr_ready", 32'(bus.dma_wr_ready), 32'd1);
        bus.fifo_tx_we_o   = 1'b1;
        bus.fifo_tx_data_o = 32'h88;
        tick();
        chk_status("after reset", 1, 1'b0, 1'b0);
        check("after reset head", bus.tx_data_fifo, 32'h88);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
